// File: rtl/pol2rec_pkg.sv
// pol2rec_pkg: constants and types shared by the polar-to-rectangular CORDIC
// converter (and reusable by the rectangular-to-polar companion).
package pol2rec_pkg;

  // 1/K gain compensation, fixed point with P2R_SCALE_SHIFT fractional bits
  localparam int P2R_SCALE       = 159188;
  localparam int P2R_SCALE_SHIFT = 18;

  // Internal datapath widths: x/y carry two guard integer bits over 16Q16
  localparam int XY_W = 34;
  localparam int Z_W  = 32;

  // Angle constants in 8Q24 degrees; 180 needs 33 bits to stay positive
  localparam logic signed [32:0] DEG180 = 33'sh0_B400_0000;
  localparam logic signed [31:0] DEG90  = 32'sh5A00_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pol2rec_cordic_if.sv
// pol2rec_cordic_if: operand/result bundle of the polar-to-rectangular converter.
interface pol2rec_cordic_if;
  logic               enable;
  logic               start;
  logic signed [31:0] mod;
  logic signed [31:0] angle;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic               busy;
  logic               done;

  modport master (output enable, start, mod, angle, input x, y, busy, done);
  modport slave  (input enable, start, mod, angle, output x, y, busy, done);
endinterface

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: atan(2^-idx) in degrees, 8Q24, truncated. Combinational.
module cordic_atan_rom (
  input  logic [4:0]         idx,
  output logic signed [31:0] atan
);

  // Table lookup of the elementary rotation angle for iteration idx
  always_comb begin
    case (idx)
      5'd0:    atan = 32'sh2D00_0000;
      5'd1:    atan = 32'sh1A90_A731;
      5'd2:    atan = 32'sh0E09_4740;
      5'd3:    atan = 32'sh0720_0112;
      5'd4:    atan = 32'sh0393_8AA6;
      5'd5:    atan = 32'sh01CA_3794;
      5'd6:    atan = 32'sh00E5_2A1A;
      5'd7:    atan = 32'sh0072_96D7;
      5'd8:    atan = 32'sh0039_4BA5;
      5'd9:    atan = 32'sh001C_A5D9;
      5'd10:   atan = 32'sh000E_52ED;
      5'd11:   atan = 32'sh0007_2976;
      5'd12:   atan = 32'sh0003_94BB;
      5'd13:   atan = 32'sh0001_CA5D;
      5'd14:   atan = 32'sh0000_E52E;
      5'd15:   atan = 32'sh0000_7297;
      5'd16:   atan = 32'sh0000_394B;
      5'd17:   atan = 32'sh0000_1CA5;
      5'd18:   atan = 32'sh0000_0E52;
      5'd19:   atan = 32'sh0000_0729;
      5'd20:   atan = 32'sh0000_0394;
      5'd21:   atan = 32'sh0000_01CA;
      5'd22:   atan = 32'sh0000_00E5;
      5'd23:   atan = 32'sh0000_0072;
      5'd24:   atan = 32'sh0000_0039;
      5'd25:   atan = 32'sh0000_001C;
      5'd26:   atan = 32'sh0000_000E;
      5'd27:   atan = 32'sh0000_0007;
      5'd28:   atan = 32'sh0000_0003;
      5'd29:   atan = 32'sh0000_0001;
      5'd30:   atan = 32'sh0000_0000;
      5'd31:   atan = 32'sh0000_0000;
      default: atan = 32'sh0000_0000;
    endcase
  end

endmodule

// File: rtl/pol2rec_cordic.sv
// pol2rec_cordic: polar (16Q16 modulus, 8Q24 degrees) to rectangular (16Q16)
// converter, CORDIC rotation mode, one iteration per enabled clock.
// Optional macro POL2REC_QUADRANT_EXT_EN: pre-rotates by 180 degrees on load so
// the full 8Q24 angle span is accepted.
module pol2rec_cordic
  import pol2rec_pkg::*;
#(
  parameter int NITER       = 32,
  parameter int SCALE       = P2R_SCALE,
  parameter int SCALE_SHIFT = P2R_SCALE_SHIFT
) (
  input  logic            clock,
  input  logic            reset,
  pol2rec_cordic_if.slave bus
);

  state_t                 state_r, state_nxt_s;
  logic signed [XY_W-1:0] xr_r, yr_r, xr_nxt_s, yr_nxt_s;
  logic signed [XY_W-1:0] scaled_s, xr_load_s;
  logic signed [Z_W-1:0]  zr_r, zr_nxt_s, zr_load_s, atan_s;
  logic signed [49:0]     prod_s;
  logic [5:0]             i_r;
  logic                   load_s, step_s, finish_s, last_s, dpos_s;
  logic signed [31:0]     x_r, y_r;
  logic                   busy_r, done_r;

  cordic_atan_rom u_atan (
    .idx  (i_r[4:0]),
    .atan (atan_s)
  );

  // Gain-compensated modulus; the 1/K factor is applied once up front
  assign prod_s   = 50'(bus.mod) * 50'(SCALE);
  assign scaled_s = XY_W'(prod_s >>> SCALE_SHIFT);
  assign last_s   = (i_r == 6'(NITER - 1));
  assign dpos_s   = ~zr_r[Z_W-1];

  // Load values for x and z, with optional half-turn pre-rotation
  always_comb begin
    xr_load_s = scaled_s;
    zr_load_s = bus.angle;
`ifdef POL2REC_QUADRANT_EXT_EN
    if (bus.angle > DEG90) begin
      xr_load_s = -scaled_s;
      zr_load_s = Z_W'(33'(bus.angle) - DEG180);
    end else if (bus.angle < -DEG90) begin
      xr_load_s = -scaled_s;
      zr_load_s = Z_W'(33'(bus.angle) + DEG180);
    end else begin
      xr_load_s = scaled_s;
      zr_load_s = bus.angle;
    end
`endif
  end

  // One micro-rotation toward driving the residual angle z to zero
  always_comb begin
    if (dpos_s) begin
      xr_nxt_s = xr_r - (yr_r >>> i_r);
      yr_nxt_s = yr_r + (xr_r >>> i_r);
      zr_nxt_s = zr_r - atan_s;
    end else begin
      xr_nxt_s = xr_r + (yr_r >>> i_r);
      yr_nxt_s = yr_r - (xr_r >>> i_r);
      zr_nxt_s = zr_r + atan_s;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a load wins from any state, DONE always falls to IDLE
  always_comb begin
    state_nxt_s = state_r;
    if (load_s) begin
      state_nxt_s = ITER;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        ITER:    state_nxt_s = (bus.enable && last_s) ? DONE : ITER;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM control strobes: load, iterate, and final iteration
  always_comb begin
    load_s = bus.start & bus.enable;
    if (!load_s && (state_r == ITER) && bus.enable) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
    finish_s = step_s & last_s;
  end

  // CORDIC working registers; frozen whenever nothing is loaded or stepped
  always_ff @(posedge clock) begin
    if (!reset) begin
      xr_r <= '0;
      yr_r <= '0;
      zr_r <= '0;
      i_r  <= 6'd0;
    end else if (load_s) begin
      xr_r <= xr_load_s;
      yr_r <= '0;
      zr_r <= zr_load_s;
      i_r  <= 6'd0;
    end else if (step_s) begin
      xr_r <= xr_nxt_s;
      yr_r <= yr_nxt_s;
      zr_r <= zr_nxt_s;
      i_r  <= i_r + 6'd1;
    end else begin
      xr_r <= xr_r;
      yr_r <= yr_r;
      zr_r <= zr_r;
      i_r  <= i_r;
    end
  end

  // Registered results and status; x/y change only on the finishing step
  always_ff @(posedge clock) begin
    if (!reset) begin
      x_r    <= 32'sd0;
      y_r    <= 32'sd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ITER);
      done_r <= finish_s;
      if (finish_s) begin
        x_r <= xr_nxt_s[31:0];
        y_r <= yr_nxt_s[31:0];
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
    end
  end

  assign bus.x    = x_r;
  assign bus.y    = y_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_pol2rec_cordic.sv
// tb_pol2rec_cordic: random and directed stimulus against a trigonometric
// reference model of the polar-to-rectangular converter.
module tb_pol2rec_cordic;

  localparam int NITER = 32;

  logic clock = 1'b0;
  logic reset;
  pol2rec_cordic_if bus ();

  pol2rec_cordic #(.NITER(NITER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level)
  bit     model_valid = 1'b0;
  bit     m_active    = 1'b0;
  bit     exp_done    = 1'b0;
  bit     exp_busy    = 1'b0;
  bit     exp_zero    = 1'b1;
  int     m_cnt       = 0;
  longint m_mod       = 0;
  longint m_ang       = 0;
  real    exp_x       = 0.0;
  real    exp_y       = 0.0;
  real    exp_tol     = 8.0;
  int     done_cnt    = 0;

  function automatic real ref_val(input longint m, input longint a, input bit is_y);
    real rad;
    rad = (real'(a) / 16777216.0) * 3.14159265358979323846 / 180.0;
    return is_y ? real'(m) * $sin(rad) : real'(m) * $cos(rad);
  endfunction

  function automatic real tol_of(input longint m);
    return 8.0 + 4.0e-6 * real'(m);
  endfunction

  task automatic chk_real(input string name, input real act, input real exp, input real tol);
    checks++;
    if ((act - exp) > tol || (exp - act) > tol) begin
      errors++;
      $display("FAIL %s: got %0.2f, expected %0.2f +/- %0.2f", name, act, exp, tol);
    end
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a conversion completes after NITER enabled cycles from its load
  always @(posedge clock) begin
    if (!reset) begin
      model_valid = 1'b1;
      m_active = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_zero = 1'b1;
    end else if (bus.start && bus.enable) begin
      m_active = 1'b1; m_cnt = 0; exp_done = 1'b0; exp_busy = 1'b1;
      m_mod = longint'(bus.mod); m_ang = longint'(bus.angle);
    end else if (m_active && bus.enable) begin
      m_cnt++;
      if (m_cnt == NITER) begin
        m_active = 1'b0; exp_done = 1'b1; exp_busy = 1'b0; exp_zero = 1'b0;
        exp_x = ref_val(m_mod, m_ang, 1'b0);
        exp_y = ref_val(m_mod, m_ang, 1'b1);
        exp_tol = tol_of(m_mod);
      end else begin
        exp_done = 1'b0;
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clock) begin
    if (model_valid) begin
      if (bus.done) done_cnt++;
      chk_eq("cyc_done", longint'(bus.done), longint'(exp_done));
      chk_eq("cyc_busy", longint'(bus.busy), longint'(exp_busy));
      if (exp_zero) begin
        chk_eq("cyc_x_zero", longint'(bus.x), 0);
        chk_eq("cyc_y_zero", longint'(bus.y), 0);
      end else begin
        chk_real("cyc_x", real'($signed(bus.x)), exp_x, exp_tol);
        chk_real("cyc_y", real'($signed(bus.y)), exp_y, exp_tol);
      end
    end
  end

  task automatic do_start(input logic signed [31:0] m, input logic signed [31:0] a);
    bus.start = 1'b1; bus.enable = 1'b1; bus.mod = m; bus.angle = a;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Run until done, freezing enable for frz_len cycles starting at cycle frz_at
  task automatic run_conv(input int frz_at, input int frz_len, input int limit,
                          output int lat, output int bsy);
    lat = 0;
    bsy = bus.busy ? 1 : 0;
    while (lat < limit) begin
      bus.enable = !(lat >= frz_at && lat < frz_at + frz_len);
      @(negedge clock);
      lat++;
      if (bus.done) break;
      if (bus.busy) bsy++;
    end
    bus.enable = 1'b1;
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bsy, dc0;
    logic signed [31:0] t1x, t1y;

    reset = 1'b0; bus.enable = 1'b0; bus.start = 1'b0;
    bus.mod = 32'sd0; bus.angle = 32'sd0;
    repeat (2) @(negedge clock);
    chk_eq("rst_x", longint'(bus.x), 0);
    chk_eq("rst_y", longint'(bus.y), 0);
    chk_eq("rst_busy", longint'(bus.busy), 0);
    chk_eq("rst_done", longint'(bus.done), 0);
    reset = 1'b1;
    @(negedge clock);

    // Pin the reference model against hand-computed values
    chk_real("pin_m100_x", ref_val(64'sh0064_0000, -64'sd754974720, 1'b0), 4634095.0, 1.0);
    chk_real("pin_m100_y", ref_val(64'sh0064_0000, -64'sd754974720, 1'b1), -4634095.0, 1.0);
    chk_real("pin_m2_x", ref_val(64'sh0002_0000, 64'sh1E00_0000, 1'b0), 113512.0, 1.0);

    // 1.0 at 0 degrees
    do_start(32'sh0001_0000, 32'sh0000_0000);
    run_conv(1000, 0, 60, lat, bsy);
    chk_eq("t1_latency", lat, 32);
    chk_eq("t1_busy_cycles", bsy, 32);
    chk_real("t1_x", real'($signed(bus.x)), 65536.0, 8.0);
    chk_real("t1_y", real'($signed(bus.y)), 0.0, 8.0);
    t1x = bus.x; t1y = bus.y;

    // 1.0 at 90 degrees (start accepted while in DONE)
    do_start(32'sh0001_0000, 32'sh5A00_0000);
    run_conv(1000, 0, 60, lat, bsy);
    chk_real("t2_x", real'($signed(bus.x)), 0.0, 8.0);
    chk_real("t2_y", real'($signed(bus.y)), 65536.0, 8.0);

    // 100 at -45 degrees
    do_start(32'sh0064_0000, 32'shD300_0000);
    run_conv(1000, 0, 60, lat, bsy);
    chk_real("t3_x", real'($signed(bus.x)), real'(32'sh0046_B5EF), 40.0);
    chk_real("t3_y", real'($signed(bus.y)), real'(32'shFFB9_4A11), 40.0);

    // Freeze for 5 cycles after 10 iterations
    do_start(32'sh0001_0000, 32'sh0000_0000);
    run_conv(10, 5, 60, lat, bsy);
    chk_eq("t4_latency", lat, 37);
    chk_eq("t4_x_same", longint'(bus.x), longint'(t1x));
    chk_eq("t4_y_same", longint'(bus.y), longint'(t1y));

    // Restart after 12 iterations: exactly one done, for the new operands
    @(negedge clock);
    do_start(32'sh0001_0000, 32'sh0000_0000);
    repeat (12) @(negedge clock);
    dc0 = done_cnt;
    do_start(32'sh0002_0000, 32'sh1E00_0000);
    run_conv(1000, 0, 60, lat, bsy);
    chk_eq("t5_latency", lat, 32);
    chk_real("t5_x", real'($signed(bus.x)), real'(32'sh0001_BB68), 16.0);
    chk_real("t5_y", real'($signed(bus.y)), real'(32'sh0001_0000), 16.0);
    @(negedge clock);
    chk_eq("t5_done_count", done_cnt - dc0, 1);

    // Reset mid-conversion discards the result
    do_start(32'sh0001_0000, 32'sh0000_0000);
    repeat (20) @(negedge clock);
    dc0 = done_cnt;
    reset = 1'b0;
    @(negedge clock);
    chk_eq("t6_x", longint'(bus.x), 0);
    chk_eq("t6_y", longint'(bus.y), 0);
    chk_eq("t6_busy", longint'(bus.busy), 0);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk_eq("t6_no_done", done_cnt - dc0, 0);

`ifdef POL2REC_QUADRANT_EXT_EN
    // 1.0 at 120 degrees, beyond the base range
    do_start(32'sh0001_0000, 32'sh7800_0000);
    run_conv(1000, 0, 60, lat, bsy);
    chk_real("t7_x", real'($signed(bus.x)), real'(32'shFFFF_8000), 8.0);
    chk_real("t7_y", real'($signed(bus.y)), real'(32'sh0000_DDB4), 8.0);
`endif

    // Random operands with occasional enable gaps
    for (int k = 0; k < 40; k++) begin
      longint m, a;
      int fa, fl;
      m = longint'($urandom_range(32'd0, 32'h7FFF_0000));
`ifdef POL2REC_QUADRANT_EXT_EN
      a = longint'($urandom_range(32'd0, 32'hFFFF_FFFF)) - 64'sd2147483648;
`else
      a = longint'($urandom_range(32'd0, 32'd3019898880)) - 64'sd1509949440;
`endif
      fa = int'($urandom_range(0, 31));
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_start(32'(m), 32'(a));
      run_conv(fa, fl, 60, lat, bsy);
      chk_eq("rnd_latency", lat, 32 + fl);
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
